// File: rtl/button_led_ctrl_if.sv
// Board-side signal bundle for button_led_ctrl: raw buttons and mode in, LED drive and press pulses out.
interface button_led_ctrl_if #(
  parameter int unsigned NUM_BUT = 2
);
  logic [NUM_BUT-1:0] BUT;
  logic [1:0]         MODE;
  logic [NUM_BUT-1:0] LED;
  logic [NUM_BUT-1:0] PRESS;

  modport master (output BUT, output MODE, input LED, input PRESS);
  modport slave  (input BUT, input MODE, output LED, output PRESS);
endinterface

// File: rtl/button_led_ctrl.sv
// Synchronise/debounce NUM_BUT active-low buttons, combine them (AND/OR/TOGGLE) and drive registered LEDs.
// Optional blinking of lit LEDs when BUTTON_LED_BLINK_EN is defined.
module button_led_ctrl #(
  parameter int unsigned NUM_BUT    = 2,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned DEB_W      = 16,
  parameter int unsigned BLINK_DIV  = 24
) (
  input  logic               CLK,
  input  logic               RST_N,
  button_led_ctrl_if.slave   btn_if
);

  typedef enum logic [1:0] {
    MODE_AND = 2'b00,
    MODE_OR  = 2'b01,
    MODE_TOG = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  if (NUM_BUT < 1 || NUM_BUT > 16 || DEB_CYCLES < 1 || DEB_W < 1 || DEB_W > 31 ||
      (DEB_CYCLES >> DEB_W) != 0 || BLINK_DIV < 1) begin : g_param_err
    $error("button_led_ctrl: illegal parameter combination");
  end

  logic [NUM_BUT-1:0] sync1, sync2;
  logic [NUM_BUT-1:0] stable, stable_d;
  logic [DEB_W-1:0]   cnt [NUM_BUT];
  logic [NUM_BUT-1:0] pe;
  logic [NUM_BUT-1:0] tog, tog_nxt;
  logic [NUM_BUT-1:0] led_nxt, led_out;
  mode_e              mode;

  assign mode = mode_e'(btn_if.MODE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_if.BUT;
      sync2 <= sync1;
    end
  end

  // Any return to the stable level clears the count, so short glitches never reach stable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable <= '1;
      for (int unsigned i = 0; i < NUM_BUT; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUT; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stable_d <= '1;
    else        stable_d <= stable;
  end

  assign pe = stable_d & ~stable;

  // Toggle output uses the post-update toggle value so it lands on the same edge as PRESS.
  always_comb begin
    tog_nxt = tog;
    if (mode == MODE_TOG) tog_nxt = tog ^ pe;
    led_nxt = '0;
    unique case (mode)
      MODE_OR:  led_nxt = {NUM_BUT{~&stable}};
      MODE_TOG: led_nxt = tog_nxt;
      default:  led_nxt = {NUM_BUT{~|stable}};
    endcase
  end

`ifdef BUTTON_LED_BLINK_EN
  logic [BLINK_DIV-1:0] blink_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) blink_cnt <= '0;
    else        blink_cnt <= blink_cnt + BLINK_DIV'(1);
  end

  assign led_out = led_nxt & {NUM_BUT{blink_cnt[BLINK_DIV-1]}};
`else
  assign led_out = led_nxt;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tog          <= '0;
      btn_if.LED   <= '0;
      btn_if.PRESS <= '0;
    end else begin
      tog          <= tog_nxt;
      btn_if.LED   <= led_out;
      btn_if.PRESS <= pe;
    end
  end

endmodule
